// File: rtl/serial_bus_master_pkg.sv
// Shared definitions for the serial memory bus: master state encoding,
// direction encoding and default field widths used by both bus ends.
package serial_bus_master_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REQ,
        ST_ID,
        ST_ADDR,
        ST_WDATA,
        ST_WAIT_START,
        ST_RDATA,
        ST_WAIT_ACK,
        ST_DONE,
        ST_ABORT
    } state_t;

    localparam logic DIR_RD  = 1'b0;
    localparam logic DIR_WRT = 1'b1;

    localparam int DEF_ADDRESS_WIDTH  = 15;
    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_SLAVE_ID_WIDTH = 3;
    localparam int DEF_TIMEOUT        = 255;
    localparam int TIMEOUT_CNT_WIDTH  = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/serial_bus_master_shift.sv
// LSB-first shift register with a field bit counter: parallel-load/serial-out
// for transmitted fields and serial-in/parallel-out for received fields.
module serial_shift_unit #(
    parameter int WIDTH     = 15,
    parameter int PAR_WIDTH = 8,
    parameter int CNT_WIDTH = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 shift,
    input  logic [CNT_WIDTH-1:0] load_len,
    input  logic [WIDTH-1:0]     load_data,
    input  logic                 serial_in,
    output logic                 serial_out,
    output logic                 last,
    output logic [PAR_WIDTH-1:0] shift_word
);

    logic [WIDTH-1:0]     shreg_reg;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0]     shreg_next;

    // Received bits enter at the top, so after PAR_WIDTH shifts the word is top-aligned.
    assign shreg_next = {serial_in, shreg_reg[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_reg <= '0;
            cnt_reg   <= '0;
        end else if (load) begin
            shreg_reg <= load_data;
            cnt_reg   <= load_len - CNT_WIDTH'(1);
        end else if (shift) begin
            shreg_reg <= shreg_next;
            if (cnt_reg != '0) begin
                cnt_reg <= cnt_reg - CNT_WIDTH'(1);
            end
        end
    end

    assign serial_out = shreg_reg[0];
    assign last       = (cnt_reg == '0);
    assign shift_word = shreg_next[WIDTH-1 -: PAR_WIDTH];

endmodule

// File: rtl/serial_bus_master.sv
// Initiator end of the single-wire serial memory bus: arbitrates, shifts out
// ID/address/write data, collects read data and reports done or abort.
module serial_bus_master
    import serial_bus_master_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int SLAVE_ID_WIDTH = DEF_SLAVE_ID_WIDTH,
    parameter int TIMEOUT        = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_rd_wrt,
    input  logic [SLAVE_ID_WIDTH-1:0] cmd_slave_id,
    input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    output logic                      arb_req,
    input  logic                      arb_grant,
    output logic                      bus_util,
    output logic                      rd_wrt,
    input  logic                      slave_busy,
    inout  wire                       data_bus_serial,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      done,
    output logic                      err
);

    localparam int SHIFT_WIDTH = max3(ADDRESS_WIDTH, DATA_WIDTH, SLAVE_ID_WIDTH);
    localparam int CNT_WIDTH   = $clog2(SHIFT_WIDTH + 1);
    localparam logic [TIMEOUT_CNT_WIDTH:0] TMO_LIMIT = (TIMEOUT_CNT_WIDTH + 1)'(TIMEOUT);

    state_t                         state_reg, state_next;
    logic [SLAVE_ID_WIDTH-1:0]      id_reg;
    logic [ADDRESS_WIDTH-1:0]       addr_reg;
    logic [DATA_WIDTH-1:0]          wdata_reg;
    logic                           rd_wrt_reg;
    logic [DATA_WIDTH-1:0]          rdata_reg;
    logic [TIMEOUT_CNT_WIDTH-1:0]   tmo_reg;
    logic                           busy_seen_reg, busy_seen_next;
    logic                           tmo_reload;
    logic                           tmo_expired;

    logic                   sh_load, sh_shift, sh_out, sh_last;
    logic [CNT_WIDTH-1:0]   sh_len;
    logic [SHIFT_WIDTH-1:0] sh_load_data;
    logic [DATA_WIDTH-1:0]  sh_word;
    logic                   tenure, drive_en;

    serial_shift_unit #(
        .WIDTH     (SHIFT_WIDTH),
        .PAR_WIDTH (DATA_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .load       (sh_load),
        .shift      (sh_shift),
        .load_len   (sh_len),
        .load_data  (sh_load_data),
        .serial_in  (data_bus_serial),
        .serial_out (sh_out),
        .last       (sh_last),
        .shift_word (sh_word)
    );

    // Abort on the cycle in which the count reaches TIMEOUT waiting cycles; TIMEOUT=0 aborts at once.
    assign tmo_expired = ({1'b0, tmo_reg} + (TIMEOUT_CNT_WIDTH + 1)'(1)) >= TMO_LIMIT;

    always_comb begin
        state_next     = state_reg;
        sh_load        = 1'b0;
        sh_shift       = 1'b0;
        sh_len         = '0;
        sh_load_data   = '0;
        tmo_reload     = 1'b0;
        busy_seen_next = busy_seen_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) state_next = ST_REQ;
            end
            ST_REQ: begin
                if (arb_grant) begin
                    state_next = ST_ID;
                    sh_load    = 1'b1;
                    sh_len     = CNT_WIDTH'(SLAVE_ID_WIDTH);
                    sh_load_data[SLAVE_ID_WIDTH-1:0] = id_reg;
                end else if (tmo_expired) begin
                    state_next = ST_ABORT;
                end
            end
            ST_ID: begin
                if (!arb_grant) begin
                    state_next = ST_ABORT;
                end else if (sh_last) begin
                    state_next = ST_ADDR;
                    sh_load    = 1'b1;
                    sh_len     = CNT_WIDTH'(ADDRESS_WIDTH);
                    sh_load_data[ADDRESS_WIDTH-1:0] = addr_reg;
                end else begin
                    sh_shift = 1'b1;
                end
            end
            ST_ADDR: begin
                if (!arb_grant) begin
                    state_next = ST_ABORT;
                end else if (sh_last) begin
                    if (rd_wrt_reg == DIR_WRT) begin
                        state_next = ST_WDATA;
                        sh_load    = 1'b1;
                        sh_len     = CNT_WIDTH'(DATA_WIDTH);
                        sh_load_data[DATA_WIDTH-1:0] = wdata_reg;
                    end else begin
                        state_next = ST_WAIT_START;
                    end
                end else begin
                    sh_shift = 1'b1;
                end
            end
            ST_WDATA: begin
                if (!arb_grant) begin
                    state_next = ST_ABORT;
                end else if (sh_last) begin
                    state_next     = ST_WAIT_ACK;
                    busy_seen_next = 1'b0;
                end else begin
                    sh_shift = 1'b1;
                end
            end
            ST_WAIT_START: begin
                if (!arb_grant) begin
                    state_next = ST_ABORT;
                end else if (slave_busy && data_bus_serial) begin
                    state_next = ST_RDATA;
                    sh_load    = 1'b1;
                    sh_len     = CNT_WIDTH'(DATA_WIDTH);
                end else if (tmo_expired) begin
                    state_next = ST_ABORT;
                end
            end
            ST_RDATA: begin
                if (!arb_grant) begin
                    state_next = ST_ABORT;
                end else begin
                    sh_shift = 1'b1;
                    if (sh_last) state_next = ST_DONE;
                end
            end
            ST_WAIT_ACK: begin
                // Rising and falling edge of slave_busy each get a full timeout window.
                if (!arb_grant) begin
                    state_next = ST_ABORT;
                end else if (!busy_seen_reg) begin
                    if (slave_busy) begin
                        busy_seen_next = 1'b1;
                        tmo_reload     = 1'b1;
                    end else if (tmo_expired) begin
                        state_next = ST_ABORT;
                    end
                end else if (!slave_busy) begin
                    state_next = ST_DONE;
                end else if (tmo_expired) begin
                    state_next = ST_ABORT;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_ABORT: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            id_reg        <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rd_wrt_reg    <= DIR_RD;
            rdata_reg     <= '0;
            tmo_reg       <= '0;
            busy_seen_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            busy_seen_reg <= busy_seen_next;
            if ((state_next != state_reg) || tmo_reload) begin
                tmo_reg <= '0;
            end else if (tmo_reg != '1) begin
                tmo_reg <= tmo_reg + TIMEOUT_CNT_WIDTH'(1);
            end
            if ((state_reg == ST_IDLE) && cmd_valid) begin
                id_reg     <= cmd_slave_id;
                addr_reg   <= cmd_addr;
                wdata_reg  <= cmd_wdata;
                rd_wrt_reg <= cmd_rd_wrt;
            end
            if ((state_reg == ST_RDATA) && (state_next == ST_DONE)) begin
                rdata_reg <= sh_word;
            end
        end
    end

    assign tenure = (state_reg == ST_ID) || (state_reg == ST_ADDR) ||
                    (state_reg == ST_WDATA) || (state_reg == ST_WAIT_START) ||
                    (state_reg == ST_RDATA) || (state_reg == ST_WAIT_ACK);

    // Grant loss and reset release the line in the same cycle, ahead of the state change.
    assign drive_en = !rst && arb_grant &&
                      ((state_reg == ST_ID) || (state_reg == ST_ADDR) || (state_reg == ST_WDATA));

    assign data_bus_serial = drive_en ? sh_out : 1'bz;

    assign cmd_ready = (state_reg == ST_IDLE);
    assign arb_req   = (state_reg == ST_REQ) || tenure;
    assign bus_util  = tenure;
    assign rd_wrt    = rd_wrt_reg;
    assign rdata     = rdata_reg;
    assign done      = (state_reg == ST_DONE);
    assign err       = (state_reg == ST_ABORT);

endmodule

// File: tb/tb_serial_bus_master.sv
// Directed bench for serial_bus_master with a bus-bit/outcome scoreboard and a
// simple slave model on the pulled-down serial line.
module tb_serial_bus_master;
    import serial_bus_master_pkg::*;

    localparam int AW = 15;
    localparam int DW = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_rd_wrt = 1'b0;
    logic [IW-1:0] cmd_slave_id = '0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          arb_req;
    logic          arb_grant = 1'b0;
    logic          bus_util;
    logic          rd_wrt;
    logic          slave_busy = 1'b0;
    logic [DW-1:0] rdata;
    logic          done;
    logic          err;
    logic          slave_oe = 1'b0;
    logic          slave_bit = 1'b0;
    wire           data_bus_serial;

    assign data_bus_serial = slave_oe ? slave_bit : 1'bz;
    pulldown (data_bus_serial);

    serial_bus_master dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_rd_wrt      (cmd_rd_wrt),
        .cmd_slave_id    (cmd_slave_id),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .arb_req         (arb_req),
        .arb_grant       (arb_grant),
        .bus_util        (bus_util),
        .rd_wrt          (rd_wrt),
        .slave_busy      (slave_busy),
        .data_bus_serial (data_bus_serial),
        .rdata           (rdata),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic          exp_bits[$];
    logic          exp_ok[$];
    logic [DW-1:0] exp_rdata[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic rw, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd);
        cmd_rd_wrt   = rw;
        cmd_slave_id = id;
        cmd_addr     = addr;
        cmd_wdata    = wd;
        cmd_valid    = 1'b1;
        tick();
        cmd_valid    = 1'b0;
    endtask

    task automatic expect_frame(input logic rw, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wd);
        for (int i = 0; i < IW; i++) exp_bits.push_back(id[i]);
        for (int i = 0; i < AW; i++) exp_bits.push_back(addr[i]);
        if (rw == DIR_WRT) begin
            for (int i = 0; i < DW; i++) exp_bits.push_back(wd[i]);
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            check("bus_bit", 32'(data_bus_serial), 32'(exp_bits.pop_front()));
            tick();
        end
    endtask

    task automatic wait_end(input string tag, input logic is_read);
        int   k;
        logic ok;
        k = 0;
        while (!(done || err) && k < 600) begin
            tick();
            k++;
        end
        check({tag, "_bounded"}, 32'(k < 600), 32'd1);
        ok = exp_ok.pop_front();
        check({tag, "_done"}, 32'(done), 32'(ok));
        check({tag, "_err"}, 32'(err), 32'(!ok));
        if (is_read && ok) check({tag, "_rdata"}, 32'(rdata), 32'(exp_rdata.pop_front()));
        $display("txn %s: done=%0b err=%0b rdata=%02h wait=%0d", tag, done, err, rdata, k);
    endtask

    task automatic check_idle_outputs(input string tag, input logic [DW-1:0] rd);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_arb_req"}, 32'(arb_req), 32'd0);
        check({tag, "_bus_util"}, 32'(bus_util), 32'd0);
        check({tag, "_rdata"}, 32'(rdata), 32'(rd));
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_line"}, 32'(data_bus_serial), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            n;
        logic [DW-1:0] rv;

        // Reset
        repeat (3) tick();
        check_idle_outputs("reset", 8'h00);
        check("reset_rd_wrt", 32'(rd_wrt), 32'd0);
        rst = 1'b0;
        tick();

        // Write ID=0 addr=5 data=A5, grant after two REQ cycles
        issue(DIR_WRT, 3'd0, 15'h0005, 8'hA5);
        exp_ok.push_back(1'b1);
        expect_frame(DIR_WRT, 3'd0, 15'h0005, 8'hA5);
        check("wr_cmd_ready", 32'(cmd_ready), 32'd0);
        check("wr_arb_req", 32'(arb_req), 32'd1);
        check("wr_util_before_grant", 32'(bus_util), 32'd0);
        tick();
        arb_grant = 1'b1;
        tick();
        drain(IW + AW + DW);
        check("wr_wait_util", 32'(bus_util), 32'd1);
        check("wr_wait_rd_wrt", 32'(rd_wrt), 32'd1);
        check("wr_wait_line_released", 32'(data_bus_serial), 32'd0);
        slave_busy = 1'b1;
        repeat (3) tick();
        slave_busy = 1'b0;
        check("wr_no_done_while_busy", 32'(done), 32'd0);
        wait_end("write1", 1'b0);
        check("wr_done_util_low", 32'(bus_util), 32'd0);
        arb_grant = 1'b0;
        tick();
        check("wr_after_cmd_ready", 32'(cmd_ready), 32'd1);
        check("wr_after_done", 32'(done), 32'd0);

        // Read ID=2 addr=7FFF, slave returns 3C
        issue(DIR_RD, 3'd2, 15'h7FFF, 8'h00);
        exp_ok.push_back(1'b1);
        exp_rdata.push_back(8'h3C);
        expect_frame(DIR_RD, 3'd2, 15'h7FFF, 8'h00);
        arb_grant = 1'b1;
        tick();
        drain(IW + AW);
        check("rd_wait_line_released", 32'(data_bus_serial), 32'd0);
        check("rd_wait_rd_wrt", 32'(rd_wrt), 32'd0);
        tick();
        tick();
        check("rd_turnaround_line", 32'(data_bus_serial), 32'd0);
        slave_busy = 1'b1;
        slave_oe   = 1'b1;
        slave_bit  = 1'b1;
        tick();
        rv = 8'h3C;
        for (int i = 0; i < DW; i++) begin
            slave_bit = rv[i];
            tick();
        end
        slave_oe   = 1'b0;
        slave_busy = 1'b0;
        wait_end("read1", 1'b1);
        arb_grant = 1'b0;
        tick();

        // Grant never arrives
        issue(DIR_WRT, 3'd1, 15'h0010, 8'h11);
        exp_ok.push_back(1'b0);
        n = 0;
        while (arb_req && n < 400) begin
            n++;
            tick();
        end
        check("nogrant_req_cycles", 32'(n), 32'd255);
        check("nogrant_rdata_kept", 32'(rdata), 32'h3C);
        wait_end("nogrant", 1'b0);
        tick();
        check_idle_outputs("nogrant_after", 8'h3C);

        // Read with a silent slave
        arb_grant = 1'b1;
        issue(DIR_RD, 3'd5, 15'h00A0, 8'h00);
        exp_ok.push_back(1'b0);
        expect_frame(DIR_RD, 3'd5, 15'h00A0, 8'h00);
        tick();
        drain(IW + AW);
        n = 0;
        while (!err && n < 400) begin
            tick();
            n++;
        end
        check("silent_wait_cycles", 32'(n), 32'd255);
        check("silent_util", 32'(bus_util), 32'd0);
        check("silent_rdata_kept", 32'(rdata), 32'h3C);
        wait_end("silent_read", 1'b0);
        arb_grant = 1'b0;
        tick();

        // Grant dropped at address bit 7
        arb_grant = 1'b1;
        issue(DIR_WRT, 3'd1, 15'h0080, 8'hFF);
        exp_ok.push_back(1'b0);
        expect_frame(DIR_WRT, 3'd1, 15'h0080, 8'hFF);
        tick();
        drain(IW + 7);
        check("gl_bit7_driven", 32'(data_bus_serial), 32'(exp_bits.pop_front()));
        arb_grant = 1'b0;
        #1;
        check("gl_line_released_now", 32'(data_bus_serial), 32'd0);
        tick();
        check("gl_line_released_next", 32'(data_bus_serial), 32'd0);
        check("gl_util", 32'(bus_util), 32'd0);
        exp_bits.delete();
        wait_end("grant_loss", 1'b0);
        tick();
        check("gl_after_cmd_ready", 32'(cmd_ready), 32'd1);

        issue(DIR_WRT, 3'd3, 15'h1234, 8'h5A);
        exp_ok.push_back(1'b1);
        expect_frame(DIR_WRT, 3'd3, 15'h1234, 8'h5A);
        arb_grant = 1'b1;
        tick();
        drain(IW + AW + DW);
        slave_busy = 1'b1;
        tick();
        slave_busy = 1'b0;
        wait_end("write2", 1'b0);
        arb_grant = 1'b0;
        tick();

        // Reset in RDATA, with a command offered while busy
        arb_grant = 1'b1;
        issue(DIR_RD, 3'd4, 15'h0100, 8'h00);
        expect_frame(DIR_RD, 3'd4, 15'h0100, 8'h00);
        tick();
        cmd_valid    = 1'b1;
        cmd_rd_wrt   = DIR_WRT;
        cmd_slave_id = 3'd7;
        cmd_addr     = 15'h7ABC;
        drain(IW + AW);
        check("busy_cmd_ignored", 32'(cmd_ready), 32'd0);
        cmd_valid  = 1'b0;
        slave_busy = 1'b1;
        slave_oe   = 1'b1;
        slave_bit  = 1'b1;
        tick();
        slave_bit = 1'b0;
        tick();
        slave_bit = 1'b1;
        tick();
        check("rst_pre_util", 32'(bus_util), 32'd1);
        slave_oe   = 1'b0;
        slave_busy = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("async_rst", 8'h00);
        check("async_rst_rd_wrt", 32'(rd_wrt), 32'd0);
        tick();
        rst       = 1'b0;
        arb_grant = 1'b0;
        tick();

        issue(DIR_WRT, 3'd6, 15'h0F0F, 8'hC3);
        exp_ok.push_back(1'b1);
        expect_frame(DIR_WRT, 3'd6, 15'h0F0F, 8'hC3);
        check("post_rst_accepted", 32'(cmd_ready), 32'd0);
        arb_grant = 1'b1;
        tick();
        drain(IW + AW + DW);
        slave_busy = 1'b1;
        repeat (2) tick();
        slave_busy = 1'b0;
        wait_end("write3", 1'b0);
        arb_grant = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
